stopwatch_cu: RTL
=================

# stopwatch_cu

Control unit that sequences the stopwatch datapath. It debounces two raw push-buttons and converts each press into a single-cycle event. A three-state FSM (STOP, RUN, CLEAR) uses those events to drive the datapath's `run` and `clear` inputs. It sits between the board button pins and the stopwatch datapath inside the stopwatch top level.

## Interface
- `DEBOUNCE_CYCLES`, default 100_000: consecutive `clk` cycles a synchronized button level must stay stable before it is accepted (1 ms at 100 MHz). Legal minimum is 2.
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `btn_run`  in  1  raw run/stop button, asynchronous to `clk`, active-high.
- `btn_clear`  in  1  raw clear button, asynchronous to `clk`, active-high.
- `run`  out  1  to datapath `run`; high exactly while the state is RUN.
- `clear`  out  1  to datapath `clear`; high exactly while the state is CLEAR (one cycle per accepted clear).
- `state`  out  2  current state for LEDs/debug: STOP=2'b00, RUN=2'b01, CLEAR=2'b10. 2'b11 is never produced.

## Operation
- Per button, the input path has four stages:
  - **Synchronizer:** a 2-flop synchronizer (`s1` → `s2`).
  - **Debounce counter:** width `$clog2(DEBOUNCE_CYCLES)`.
    - If `s2` equals the debounced level `db`, the counter is forced to 0.
    - Otherwise, if the counter equals `DEBOUNCE_CYCLES-1`, then `db <= s2` and the counter goes to 0.
    - Otherwise the counter increments.
  - **Edge detector:** register `db_d <= db`; press pulse = `db & ~db_d` (combinational, one cycle wide).
  - **Releases** produce no event.
- FSM, registered state with Moore outputs decoded from the state register:
  - **STOP:**
    - run pulse → RUN;
    - else clear pulse → CLEAR;
    - else stay.
  - **RUN:**
    - run pulse → STOP;
    - clear pulse ignored, stay in RUN.
  - **CLEAR:** unconditionally → STOP on the next edge; any pulses arriving in that cycle are dropped.
- When both pulses arrive in the same cycle, the run pulse wins in STOP and in RUN.
- Holding a button produces exactly one pulse. A new pulse requires a debounced release (stable low ≥ `DEBOUNCE_CYCLES`) followed by a debounced press.
- A level change on `s2` shorter than `DEBOUNCE_CYCLES` cycles resets the counter and never changes `db`.
- The two button channels are fully independent; the same debounce module is instantiated twice.

## Timing
- **Reset (asynchronous, takes effect immediately):**
  - `s1`, `s2`, `db`, `db_d` and the counters go to 0;
  - state goes to STOP;
  - `run`=0, `clear`=0, `state`=2'b00.
- **Press latency:** edge 1 is the first `clk` edge that samples a raw button high, and the button is held stable.
  - `s2`=1 after edge 2.
  - `db`=1 after edge `DEBOUNCE_CYCLES+2`.
  - The pulse is high during the following cycle.
  - The state and outputs change after edge `DEBOUNCE_CYCLES+3`.
- **`clear` width:** `clear` is high for exactly one cycle (the CLEAR state). `run` is low during CLEAR and after it.
- **No combinational paths:** there is no combinational path from `btn_*` to any output. All outputs are flop-driven or decoded from the state register only.
- **Reset mid-operation:** a reset during debounce counting, during RUN or during CLEAR aborts everything. A button still held when reset releases must be re-debounced from `db`=0, so it produces one fresh press event `DEBOUNCE_CYCLES+3` edges after release.

## Test plan
All tests use `DEBOUNCE_CYCLES`=4.
1. **Reset values:** assert `reset` mid-cycle → `run`=0, `clear`=0, `state`=00 immediately, with no clock edge required.
2. **Run press:** hold `btn_run` from edge 1 → `run`=1 and `state`=01 after edge 7. A second debounced press after a release returns to `run`=0 and `state`=00.
3. **Glitch rejection:** `btn_run` high for 3 cycles, then low → `db` never rises and `state` stays 00. Repeat with 4 stable cycles (after sync) → a transition occurs.
4. **Clear from STOP:** press `btn_clear` → `state`=10 and `clear`=1 for exactly one cycle, then `state`=00. Holding the button 100 cycles longer yields no second clear.
5. **Clear in RUN:** in RUN, press `btn_clear` → no change, with `clear`=0 throughout. Simultaneous run and clear presses in STOP → RUN, with `clear` never asserted.
6. **Reset mid-run:** in RUN with `btn_run` still held, pulse `reset` → state 00. After release, exactly one press event moves the FSM to RUN 7 edges later.

Source files
------------

// File: rtl/stopwatch_cu.sv
// Stopwatch control unit: two debounced push-button channels feed a
// STOP/RUN/CLEAR Moore FSM that drives the datapath run and clear inputs.

module stopwatch_cu_debounce #(
    parameter int DEBOUNCE_CYCLES = 100_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic press_o
);
    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s2_q;
    logic             db_q, db_d;
    logic             db_dly_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronized level disagrees with the
    // accepted level, so any bounce shorter than the window restarts it.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // through the block can leave it unassigned and infer a latch.
        cnt_d = '0;
        db_d  = db_q;
        if (s2_q != db_q) begin
            if (cnt_q == CNT_MAX) begin
                db_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; s2_q <= s1_q relies on this ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            cnt_q    <= '0;
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
        end else begin
            s1_q     <= btn_i;
            s2_q     <= s1_q;
            cnt_q    <= cnt_d;
            db_q     <= db_d;
            db_dly_q <= db_q;
        end
    end

    assign press_o = db_q & ~db_dly_q;

endmodule

module stopwatch_cu #(
    parameter int DEBOUNCE_CYCLES = 100_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_run,
    input  logic       btn_clear,
    output logic       run,
    output logic       clear,
    output logic [1:0] state
);
    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_RUN   = 2'b01,
        ST_CLEAR = 2'b10
    } state_e;

    state_e state_q, state_d;
    logic   run_press, clear_press;

    stopwatch_cu_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_run (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (btn_run),
        .press_o(run_press)
    );

    stopwatch_cu_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_clear (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (btn_clear),
        .press_o(clear_press)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_STOP;
        end else begin
            state_q <= state_d;
        end
    end

    // Run has priority over clear; CLEAR lasts one cycle and drops any pulse.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP: begin
                if (run_press) begin
                    state_d = ST_RUN;
                end else if (clear_press) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_RUN: begin
                if (run_press) begin
                    state_d = ST_STOP;
                end
            end
            ST_CLEAR: state_d = ST_STOP;
            default:  state_d = ST_STOP;
        endcase
    end

    assign run   = (state_q == ST_RUN);
    assign clear = (state_q == ST_CLEAR);
    assign state = state_q;

endmodule
